// File: rtl/rect_filler_pkg.sv
// rect_filler_pkg: frame buffer geometry, pixel format and fill FSM encoding
// shared by the rectangle filler and the video renderer.
package rect_filler_pkg;
    localparam int FB_W  = 256;
    localparam int FB_H  = 192;
    localparam int RGB_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_CLIP, S_FILL, S_DONE} state_t;

    // Checkerboard picks col1 on odd (x+y) parity.
    function automatic logic [RGB_W-1:0] pick_col(
        input logic             mode,
        input logic [RGB_W-1:0] col0,
        input logic [RGB_W-1:0] col1,
        input logic [7:0]       x,
        input logic [7:0]       y
    );
        return (mode && (x[0] ^ y[0])) ? col1 : col0;
    endfunction
endpackage

// File: rtl/rect_clip.sv
// rect_clip: clips a rectangle to the frame buffer and flags empty rectangles.
module rect_clip #(
    parameter int FB_W = 256,
    parameter int FB_H = 192
) (
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [8:0] w_i,
    input  logic [8:0] h_i,
    output logic [7:0] xe_o,
    output logic [7:0] ye_o,
    output logic       empty_o
);
    localparam logic [8:0] XM = 9'(FB_W - 1);
    localparam logic [8:0] YM = 9'(FB_H - 1);

    logic [8:0] xs, ys;

    assign xs      = {1'b0, x_i} + w_i - 9'd1;
    assign ys      = {1'b0, y_i} + h_i - 9'd1;
    assign xe_o    = (xs > XM) ? XM[7:0] : xs[7:0];
    assign ye_o    = (ys > YM) ? YM[7:0] : ys[7:0];
    assign empty_o = (w_i == 9'd0) || (h_i == 9'd0) || ({1'b0, y_i} > YM);
endmodule

// File: rtl/rect_filler.sv
// rect_filler: fills a clipped rectangle in the frame buffer, one pixel per
// cycle in row-major order, solid or checkerboard.
module rect_filler #(
    parameter int FB_W = rect_filler_pkg::FB_W,
    parameter int FB_H = rect_filler_pkg::FB_H
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [7:0]                        cmd_x,
    input  logic [7:0]                        cmd_y,
    input  logic [8:0]                        cmd_w,
    input  logic [8:0]                        cmd_h,
    input  logic                              cmd_mode,
    input  logic [rect_filler_pkg::RGB_W-1:0] cmd_col0,
    input  logic [rect_filler_pkg::RGB_W-1:0] cmd_col1,
    output logic                              b_w_en,
    output logic [15:0]                       b_w_ad,
    output logic [rect_filler_pkg::RGB_W-1:0] b_w_wd,
    output logic                              done
);
    import rect_filler_pkg::*;

    state_t           state_q;
    logic             ready_q, done_q, en_q, mode_q;
    logic [RGB_W-1:0] wd_q, c0_q, c1_q;
    logic [7:0]       cx_q, cy_q, x_q, y_q, xe, ye;
    logic [8:0]       w_q, h_q;
    logic             empty;

    rect_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
        .x_i(x_q), .y_i(y_q), .w_i(w_q), .h_i(h_q),
        .xe_o(xe), .ye_o(ye), .empty_o(empty)
    );

    assign cmd_ready = ready_q;
    assign b_w_en    = en_q;
    assign b_w_ad    = {cy_q, cx_q};
    assign b_w_wd    = wd_q;
    assign done      = done_q;

    // Outputs are registered alongside the state, so b_w_en is high exactly in FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            wd_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            mode_q  <= 1'b0;
            c0_q    <= '0;
            c1_q    <= '0;
        end else begin
            done_q <= 1'b0;
            en_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        state_q <= S_CLIP;
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        mode_q  <= cmd_mode;
                        c0_q    <= cmd_col0;
                        c1_q    <= cmd_col1;
                    end
                end
                S_CLIP: begin
                    if (empty) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FILL;
                        en_q    <= 1'b1;
                        cx_q    <= x_q;
                        cy_q    <= y_q;
                        wd_q    <= pick_col(mode_q, c0_q, c1_q, x_q, y_q);
                    end
                end
                S_FILL: begin
                    if (cx_q != xe) begin
                        en_q <= 1'b1;
                        cx_q <= cx_q + 8'd1;
                        wd_q <= pick_col(mode_q, c0_q, c1_q, cx_q + 8'd1, cy_q);
                    end else if (cy_q != ye) begin
                        en_q <= 1'b1;
                        cx_q <= x_q;
                        cy_q <= cy_q + 8'd1;
                        wd_q <= pick_col(mode_q, c0_q, c1_q, x_q, cy_q + 8'd1);
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rect_filler.sv
// tb_rect_filler: directed and random rectangle commands checked against a
// pixel-list reference model of the clipped rectangle.
module tb_rect_filler;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [7:0]  cmd_x, cmd_y, cmd_col0, cmd_col1;
    logic [8:0]  cmd_w, cmd_h;
    logic        b_w_en, done;
    logic [15:0] b_w_ad;
    logic [7:0]  b_w_wd;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];
    logic [15:0] last_ad;

    always #5 clk = ~clk;

    rect_filler dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_mode(cmd_mode), .cmd_col0(cmd_col0), .cmd_col1(cmd_col1),
        .b_w_en(b_w_en), .b_w_ad(b_w_ad), .b_w_wd(b_w_wd), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected pixel list: every in-frame pixel of the rectangle, row by row.
    task automatic model(input int x, input int y, input int w, input int h,
                         input bit mode, input logic [7:0] c0, input logic [7:0] c1);
        int xe, ye;
        exp_q.delete();
        if (w == 0 || h == 0 || y >= 192) return;
        xe = (x + w - 1 > 255) ? 255 : x + w - 1;
        ye = (y + h - 1 > 191) ? 191 : y + h - 1;
        for (int yy = y; yy <= ye; yy++)
            for (int xx = x; xx <= xe; xx++)
                exp_q.push_back({8'(yy), 8'(xx), (mode && ((xx + yy) % 2 == 1)) ? c1 : c0});
    endtask

    task automatic issue(input int x, input int y, input int w, input int h,
                         input bit mode, input logic [7:0] c0, input logic [7:0] c1);
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check("ready_before", 32'(cmd_ready), 1);
        cmd_x     = 8'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 9'(h);
        cmd_mode  = mode;
        cmd_col0  = c0;
        cmd_col1  = c1;
        cmd_valid = 1'b1;
        tick();
    endtask

    task automatic run(input int x, input int y, input int w, input int h,
                       input bit mode, input logic [7:0] c0, input logic [7:0] c1, input bit hold);
        int n, t_first, t_done, bad_rdy, budget, nexp;
        model(x, y, w, h, mode, c0, c1);
        nexp    = exp_q.size();
        n       = 0;
        t_first = -1;
        t_done  = -1;
        bad_rdy = 0;
        budget  = nexp + 10;
        issue(x, y, w, h, mode, c0, c1);
        if (!hold) cmd_valid = 1'b0;
        for (int t = 1; t <= budget && t_done < 0; t++) begin
            tick();
            if (b_w_en) begin
                if (t_first < 0) t_first = t;
                if (n < nexp) begin
                    check("wr_ad", 32'(b_w_ad), 32'(exp_q[n][23:8]));
                    check("wr_wd", 32'(b_w_wd), 32'(exp_q[n][7:0]));
                end
                n++;
                last_ad = b_w_ad;
            end
            if (done) begin
                t_done    = t;
                cmd_valid = 1'b0;
            end else if (cmd_ready) bad_rdy++;
        end
        check("wr_count", 32'(n), 32'(nexp));
        check("done_seen", 32'(t_done >= 0), 1);
        check("done_time", 32'(t_done), (nexp == 0) ? 32'd1 : 32'(nexp + 1));
        if (nexp > 0) check("first_wr", 32'(t_first), 1);
        check("ready_busy", 32'(bad_rdy), 0);
        check("ready_at_done", 32'(cmd_ready), 0);
        tick();
        check("ready_after", 32'(cmd_ready), 1);
        check("done_pulse", 32'(done), 0);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_col0  = '0;
        cmd_col1  = '0;
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_en", 32'(b_w_en), 0);
        check("rst_ad", 32'(b_w_ad), 0);
        check("rst_wd", 32'(b_w_wd), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();
        check("ready_post_rst", 32'(cmd_ready), 1);

        run(10, 20, 3, 2, 1'b0, 8'hE0, 8'h1C, 1'b0);
        run(250, 190, 20, 10, 1'b0, 8'h03, 8'h00, 1'b0);
        check("clip_last", 32'(last_ad), 32'hBFFF);
        run(10, 10, 0, 5, 1'b0, 8'h11, 8'h22, 1'b0);
        run(10, 192, 5, 5, 1'b0, 8'h11, 8'h22, 1'b0);
        run(0, 0, 2, 2, 1'b1, 8'h00, 8'hFF, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int x, y, w, h;
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 199);
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
            h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
            if ($urandom_range(0, 4) == 0) begin
                w = 256;
                h = $urandom_range(1, 3);
            end
            run(x, y, w, h, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        // Full screen with cmd_valid held: nothing may be taken while busy.
        run(0, 0, 256, 256, 1'b1, 8'h49, 8'hB6, 1'b1);
        tick();
        check("no_requeue_en", 32'(b_w_en), 0);
        check("no_requeue_rdy", 32'(cmd_ready), 1);

        issue(0, 0, 256, 256, 1'b0, 8'h5A, 8'h00);
        cmd_valid = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && seen < 5; t++) begin
            tick();
            if (b_w_en) seen++;
        end
        check("pre_rst_writes", 32'(seen), 5);
        rst = 1'b1;
        tick();
        check("mid_rst_en", 32'(b_w_en), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_ready", 32'(cmd_ready), 0);
        check("mid_rst_ad", 32'(b_w_ad), 0);
        tick();
        check("mid_rst_done2", 32'(done), 0);
        rst = 1'b0;
        tick();
        check("rst_release_ready", 32'(cmd_ready), 1);
        check("rst_release_en", 32'(b_w_en), 0);
        check("rst_release_done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
